// File: rtl/billing_pkg.sv
// rtl/billing_pkg.sv - shared coin encodings, state enum and coin helpers for cart and checkout
package billing_pkg;

    localparam int BILL_W   = 8;
    localparam int CREDIT_W = 9;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHANGE  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [3:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_1:  return 4'd1;
            COIN_2:  return 4'd2;
            COIN_5:  return 4'd5;
            default: return 4'd10;
        endcase
    endfunction

    // Largest denomination not exceeding the amount still owed back.
    function automatic logic [1:0] greedy_coin(input logic [BILL_W-1:0] amount);
        if (amount >= BILL_W'(10))
            return COIN_10;
        else if (amount >= BILL_W'(5))
            return COIN_5;
        else if (amount >= BILL_W'(2))
            return COIN_2;
        else
            return COIN_1;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out a loaded amount as greedy coins over a valid/ready handshake
module change_dispenser
    import billing_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BILL_W-1:0] amount,
    input  logic              ready,
    output logic              valid,
    output logic [1:0]        coin_type,
    output logic              done
);

    logic [BILL_W-1:0] change_r;
    logic [BILL_W-1:0] coin_amt;
    logic              xfer;

    // Offer is decoded from the register only, so it never depends on ready.
    assign coin_type = greedy_coin(change_r);
    assign coin_amt  = {{(BILL_W-4){1'b0}}, coin_value(coin_type)};
    assign valid     = (change_r != '0);
    assign xfer      = valid && ready;
    assign done      = xfer && (change_r == coin_amt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            change_r <= '0;
        else if (load)
            change_r <= amount;
        else if (xfer)
            change_r <= change_r - coin_amt;
    end

endmodule

// File: rtl/payment_terminal.sv
// rtl/payment_terminal.sv - checkout FSM: collects coins against a bill, pays change or refunds on timeout
module payment_terminal
    import billing_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Pay,
    input  logic [BILL_W-1:0] Bill,
    input  logic              Coin_valid,
    input  logic [1:0]        Coin_type,
    output logic              Busy,
    output logic [BILL_W-1:0] Due,
    output logic              Chg_valid,
    output logic [1:0]        Chg_type,
    input  logic              Chg_ready,
    output logic              Paid,
    output logic              Abort
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t              state, state_n;
    logic [BILL_W-1:0]   due_r;
    logic [CREDIT_W-1:0] credit_r;
    logic [TMO_W-1:0]    tmo_r;
    logic                abort_r;

    logic [CREDIT_W-1:0] due_ext;
    logic [CREDIT_W-1:0] credit_next;
    logic [CREDIT_W-1:0] surplus;
    logic                coin_acc;
    logic                covered;
    logic                tmo_hit;

    logic                disp_load;
    logic [BILL_W-1:0]   disp_amount;
    logic                disp_done;

    assign due_ext     = {1'b0, due_r};
    assign credit_next = credit_r + {{(CREDIT_W-4){1'b0}}, coin_value(Coin_type)};
    assign surplus     = credit_next - due_ext;
    assign coin_acc    = (state == ST_COLLECT) && Coin_valid;
    assign covered     = credit_next >= due_ext;
    // A coin in the same cycle always beats the timeout.
    assign tmo_hit     = (state == ST_COLLECT) && !Coin_valid && (tmo_r == TMO_LAST);

    always_comb begin
        state_n     = state;
        disp_load   = 1'b0;
        disp_amount = '0;
        case (state)
            ST_IDLE: begin
                if (Pay)
                    state_n = (Bill == '0) ? ST_DONE : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (coin_acc) begin
                    if (covered) begin
                        if (surplus != '0) begin
                            state_n     = ST_CHANGE;
                            disp_load   = 1'b1;
                            disp_amount = surplus[BILL_W-1:0];
                        end else begin
                            state_n = ST_DONE;
                        end
                    end
                end else if (tmo_hit) begin
                    disp_load   = 1'b1;
                    disp_amount = credit_r[BILL_W-1:0];
                    state_n     = (credit_r != '0) ? ST_CHANGE : ST_DONE;
                end
            end
            ST_CHANGE: begin
                if (disp_done)
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= ST_IDLE;
            due_r    <= '0;
            credit_r <= '0;
            tmo_r    <= '0;
            abort_r  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (Pay) begin
                        due_r    <= Bill;
                        credit_r <= '0;
                        tmo_r    <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (Coin_valid) begin
                        credit_r <= credit_next;
                        tmo_r    <= '0;
                    end else if (tmo_hit) begin
                        abort_r <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    abort_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    change_dispenser u_change_dispenser (
        .clk       (Clk),
        .rst_n     (Rst),
        .load      (disp_load),
        .amount    (disp_amount),
        .ready     (Chg_ready),
        .valid     (Chg_valid),
        .coin_type (Chg_type),
        .done      (disp_done)
    );

    assign Busy  = (state != ST_IDLE);
    assign Due   = ((state == ST_COLLECT) && (due_ext > credit_r))
                 ? (due_r - credit_r[BILL_W-1:0]) : '0;
    assign Paid  = (state == ST_DONE) && !abort_r;
    assign Abort = (state == ST_DONE) && abort_r;

endmodule

// File: tb/tb_payment_terminal.sv
// tb/tb_payment_terminal.sv - vector table plus scoreboard bench for payment_terminal
module tb_payment_terminal;

    localparam int TMO = 20;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Pay = 1'b0;
    logic [7:0] Bill = '0;
    logic       Coin_valid = 1'b0;
    logic [1:0] Coin_type = '0;
    logic       Chg_ready = 1'b1;
    logic       Busy, Chg_valid, Paid, Abort;
    logic [7:0] Due;
    logic [1:0] Chg_type;

    int total  = 0;
    int passed = 0;

    logic [1:0] exp_chg[$];
    logic [1:0] exp_out[$];

    typedef struct {
        logic [7:0]      bill;
        int              n;
        logic [5:0][1:0] coins;
        int              change;
    } vec_t;

    vec_t vecs[6];

    payment_terminal #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Pay        (Pay),
        .Bill       (Bill),
        .Coin_valid (Coin_valid),
        .Coin_type  (Coin_type),
        .Busy       (Busy),
        .Due        (Due),
        .Chg_valid  (Chg_valid),
        .Chg_type   (Chg_type),
        .Chg_ready  (Chg_ready),
        .Paid       (Paid),
        .Abort      (Abort)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic [7:0] b, input int n, input logic [11:0] c, input int ch);
        vec_t v;
        v.bill   = b;
        v.n      = n;
        v.coins  = c;
        v.change = ch;
        return v;
    endfunction

    function automatic int cv(input logic [1:0] t);
        int tbl [4] = '{1, 2, 5, 10};
        return tbl[t];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_change(input int c);
        int r;
        r = c;
        repeat (r / 10) exp_chg.push_back(2'b11);
        r = r % 10;
        repeat (r / 5) exp_chg.push_back(2'b10);
        r = r % 5;
        repeat (r / 2) exp_chg.push_back(2'b01);
        repeat (r % 2) exp_chg.push_back(2'b00);
    endtask

    task automatic sample_obs();
        if (Chg_valid && Chg_ready) begin
            if (exp_chg.size() == 0) begin
                total++;
                $display("FAIL chg_unexpected: got type %0d expected no transfer", Chg_type);
            end else begin
                chk("chg_type", Chg_type, exp_chg.pop_front());
            end
        end
        if (Paid || Abort) begin
            if (exp_out.size() == 0) begin
                total++;
                $display("FAIL outcome_unexpected: got abort/paid %b expected none", {Abort, Paid});
            end else begin
                chk("outcome", {Abort, Paid}, exp_out.pop_front());
            end
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
        sample_obs();
        @(posedge Clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        Coin_valid = 1'b1;
        Coin_type  = t;
        cyc();
        Coin_valid = 1'b0;
    endtask

    task automatic pay(input logic [7:0] b);
        Pay  = 1'b1;
        Bill = b;
        cyc();
        Pay  = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int i;
        i = 0;
        while (Busy && i < 300) begin
            Chg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            i++;
        end
        chk("idle_reached", Busy, 0);
        chk("chg_queue_drained", exp_chg.size(), 0);
        chk("outcome_seen", exp_out.size(), 0);
        Chg_ready = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input bit rnd);
        int credit;
        push_change(v.change);
        exp_out.push_back(2'b01);
        pay(v.bill);
        chk("busy_after_pay", Busy, 1);
        if (v.bill == 0)
            chk("zero_bill_paid", Paid, 1);
        else
            chk("due_after_pay", Due, v.bill);
        credit = 0;
        for (int k = 0; k < v.n; k++) begin
            coin(v.coins[5-k]);
            credit += cv(v.coins[5-k]);
            chk("due_after_coin", Due, (credit < v.bill) ? v.bill - credit : 0);
        end
        wait_idle(rnd);
    endtask

    initial begin
        int n;
        vecs[0] = mk(8'd37, 5, {2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00}, 0);
        vecs[1] = mk(8'd13, 2, {2'b11, 2'b11, 8'h00}, 7);
        vecs[2] = mk(8'd1,  1, {2'b11, 10'h000}, 9);
        vecs[3] = mk(8'd24, 3, {2'b11, 2'b11, 2'b10, 6'h00}, 1);
        vecs[4] = mk(8'd0,  0, 12'h000, 0);
        vecs[5] = mk(8'd8,  4, {2'b01, 2'b01, 2'b01, 2'b01, 4'h0}, 0);

        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_due", Due, 0);
        chk("rst_chg_valid", Chg_valid, 0);
        chk("rst_chg_type", Chg_type, 0);
        chk("rst_paid", Paid, 0);
        chk("rst_abort", Abort, 0);
        cyc();
        Rst = 1'b1;
        cyc();

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], bit'(i % 2));

        // Dispenser stall: offer must hold, Paid one cycle after the final handshake.
        push_change(7);
        exp_out.push_back(2'b01);
        Chg_ready = 1'b0;
        pay(8'd13);
        coin(2'b11);
        coin(2'b11);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", Chg_valid, 1);
            chk("stall_type", Chg_type, 2'b10);
            cyc();
        end
        Chg_ready = 1'b1;
        cyc();
        cyc();
        chk("paid_after_last_xfer", Paid, 1);
        wait_idle(0);

        // Timeout refund.
        push_change(5);
        exp_out.push_back(2'b10);
        Chg_ready = 1'b0;
        pay(8'd20);
        coin(2'b10);
        chk("timeout_due", Due, 15);
        n = 1;
        while (!Chg_valid && n < TMO + 50) begin
            cyc();
            n++;
        end
        chk("timeout_latency", n, TMO + 1);
        chk("refund_type", Chg_type, 2'b10);
        wait_idle(0);

        // Coin landing on the timeout cycle keeps the transaction alive.
        exp_out.push_back(2'b01);
        pay(8'd20);
        coin(2'b10);
        repeat (TMO - 1) cyc();
        coin(2'b10);
        chk("late_coin_due", Due, 10);
        chk("late_coin_busy", Busy, 1);
        chk("late_coin_no_chg", Chg_valid, 0);
        coin(2'b11);
        wait_idle(0);

        // Coins in IDLE and Pay while busy are ignored.
        coin(2'b11);
        chk("idle_coin_busy", Busy, 0);
        exp_out.push_back(2'b01);
        pay(8'd30);
        chk("due_ignores_idle_coin", Due, 30);
        coin(2'b11);
        chk("due_after_10", Due, 20);
        pay(8'd5);
        chk("pay_while_busy_due", Due, 20);
        coin(2'b11);
        chk("due_after_20", Due, 10);
        coin(2'b11);
        wait_idle(0);

        // Asynchronous reset in the middle of CHANGE.
        Chg_ready = 1'b0;
        pay(8'd13);
        coin(2'b11);
        coin(2'b11);
        chk("pre_reset_chg_valid", Chg_valid, 1);
        Rst = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_due", Due, 0);
        chk("arst_chg_valid", Chg_valid, 0);
        chk("arst_chg_type", Chg_type, 0);
        chk("arst_paid", Paid, 0);
        chk("arst_abort", Abort, 0);
        exp_chg.delete();
        exp_out.delete();
        Chg_ready = 1'b1;
        cyc();
        Rst = 1'b1;
        cyc();
        run_vec(mk(8'd5, 1, {2'b10, 10'h000}, 0), 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
